data_memory_unit: RTL and testbench

Parametrised, handshaked data memory for the MIPS datapath. It replaces the combinational word-only data memory with byte, halfword and word loads and stores, signed and unsigned load extension, and a configurable read latency. It also detects misaligned and out-of-range addresses. It sits between the ALU address output and the write-back mux, and gives the multicycle core a stall-aware interface.

---
 rtl/data_memory_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_data_memory_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// ---------------------------------------------------------------------------
// data_memory_unit
//
// Handshaked byte-addressable data memory for the MIPS datapath. Supports
// byte / halfword / word loads and stores (big-endian), signed or unsigned
// load extension, a configurable read latency, and flags misaligned or
// out-of-range accesses as errors. One request is outstanding at a time.
//
// Parameters
//   DEPTH_BYTES   memory size in bytes (power of two, >= 4)
//   ADDR_WIDTH    width of req_addr
//   READ_LATENCY  cycles from load acceptance to rsp_valid (1..4)
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset (memory contents kept)
//   req_valid     request present
//   req_ready     unit can accept a request (registered)
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     response present
//   rsp_ready     consumer takes the response
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_error     request rejected
// ---------------------------------------------------------------------------
module data_memory_unit #(
  parameter int DEPTH_BYTES  = 4096,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int MEM_AW = $clog2(DEPTH_BYTES);
  localparam int EXT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Big-endian byte store; never reset.
  logic [7:0] mem [DEPTH_BYTES];

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic                accept;
  logic                req_err;
  logic                misaligned;
  logic                out_of_range;
  logic [EXT_W-1:0]    span;
  logic [EXT_W-1:0]    last_byte;
  logic [MEM_AW-1:0]   idx0, idx1, idx2, idx3;
  logic                mem_we;
  logic [31:0]         load_word;

  // Sign/zero extension of the addressed bytes, b0 being the lowest address.
  function automatic logic [31:0] extend_load(input logic [1:0] size,
                                              input logic       uns,
                                              input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3);
    logic [31:0] res;
    case (size)
      2'b00:   res = uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   res = uns ? {16'h0, b0, b1} : {{16{b0[7]}}, b0, b1};
      default: res = {b0, b1, b2, b3};
    endcase
    return res;
  endfunction

  assign accept = req_valid && req_ready_q && (state_q == ST_IDLE);

  // Request decode. The range check is one bit wider than the address so
  // that addr + 3 cannot wrap back into range.
  always_comb begin
    span = '0;
    case (req_size)
      2'b01:   span = EXT_W'(1);
      2'b10:   span = EXT_W'(3);
      default: span = '0;
    endcase
    last_byte    = {1'b0, req_addr} + span;
    out_of_range = (last_byte >= EXT_W'(DEPTH_BYTES));
    misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err      = (req_size == 2'b11) || misaligned || out_of_range;
  end

  // Byte lane indices wrap inside the array; wrapped lanes only occur for
  // out-of-range requests, whose data is discarded.
  assign idx0 = req_addr[MEM_AW-1:0];
  assign idx1 = idx0 + MEM_AW'(1);
  assign idx2 = idx0 + MEM_AW'(2);
  assign idx3 = idx0 + MEM_AW'(3);

  assign mem_we    = accept && req_write && !req_err;
  assign load_word = (req_write || req_err) ? 32'h0 :
                     extend_load(req_size, req_unsigned,
                                 mem[idx0], mem[idx1], mem[idx2], mem[idx3]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    err_d       = err_q;
    data_d      = accept ? load_word : data_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          err_d       = req_err;
          if (req_err || req_write || (READ_LATENCY == 1)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 3'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q >= 3'(READ_LATENCY - 1)) begin
          state_d = ST_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RESP: begin
        // First cycle in RESP launches the response; it is then held
        // until the consumer takes it.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = data_q;
          rsp_error_d = err_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      err_q       <= err_d;
    end
  end

  // Storage and load-data capture; store commits on the acceptance edge.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (mem_we) begin
      case (req_size)
        2'b00: begin
          mem[idx0] <= req_wdata[7:0];
        end
        2'b01: begin
          mem[idx0] <= req_wdata[15:8];
          mem[idx1] <= req_wdata[7:0];
        end
        default: begin
          mem[idx0] <= req_wdata[31:24];
          mem[idx1] <= req_wdata[23:16];
          mem[idx2] <= req_wdata[15:8];
          mem[idx3] <= req_wdata[7:0];
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// ---------------------------------------------------------------------------
// tb_data_memory_unit
//
// Directed and randomized stimulus for data_memory_unit (READ_LATENCY = 3)
// against a byte-array reference model.
// ---------------------------------------------------------------------------
module tb_data_memory_unit;

  localparam int DEPTH = 4096;
  localparam int AW    = 32;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [7:0] mm [DEPTH];

  data_memory_unit #(
    .DEPTH_BYTES (DEPTH),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: big-endian byte array, rules applied directly.
  function automatic void model_op(input logic wr, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic er, output int lat);
    int n;
    longint last;
    logic [31:0] v;
    logic [31:0] t;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'(a) + longint'(n) - 1;
    er   = (sz == 2'd3) || ((a % n) != 0) || (last >= longint'(DEPTH));
    rd   = 32'h0;
    lat  = (er || wr) ? 1 : LAT;
    if (er) return;
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        t = wd >> (8 * (n - 1 - k));
        mm[a + k] = t[7:0];
      end
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, mm[a + k]};
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      rd = v;
    end
  endfunction

  task automatic send_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
    int guard = 0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_seen", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("ready_drop", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 12);
  endtask

  task automatic run_op(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer;
    int          elat;
    int          lat;
    model_op(wr, sz, uns, a, wd, erd, eer, elat);
    send_req(wr, sz, uns, a, wd);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    rd = rsp_rdata;
    chk({tag, "_rdata"}, rsp_rdata, erd);
    chk({tag, "_err"}, 32'(rsp_error), 32'(eer));
    @(posedge clk);
    #1;
    chk({tag, "_hs"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog chk=%0d err=%0d", chk_cnt, err_cnt);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] erd;
    logic        eer;
    int          elat;
    int          lat;
    logic        seen;
    logic        e_wr [4];
    logic [1:0]  e_sz [4];
    logic [31:0] e_a  [4];

    // Reset with a request already pending.
    reset_n = 1'b0; req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_error", 32'(rsp_error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_ready_pre_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rel_no_accept", 32'(rsp_valid), 32'd0);

    // Word store / load.
    run_op("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    run_op("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    chk("lw10_lit", rd, 32'hDEADBEEF);

    // Sub-word extension.
    run_op("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, rd);
    run_op("lb20", 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, rd);
    chk("lb20_lit", rd, 32'hFFFFFF80);
    run_op("lbu20", 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, rd);
    chk("lbu20_lit", rd, 32'h00000080);
    run_op("lh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd);
    chk("lh22_lit", rd, 32'h00007F01);
    run_op("lhu20", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, rd);
    chk("lhu20_lit", rd, 32'h000080FF);
    run_op("sb23", 1'b1, 2'd0, 1'b0, 32'h23, 32'h00000055, rd);
    run_op("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
    chk("lw20_lit", rd, 32'h80FF7F55);

    // Error cases, each followed by a read of 0x30.
    run_op("sw30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, rd);
    e_wr[0] = 1'b0; e_sz[0] = 2'd1; e_a[0] = 32'h21;
    e_wr[1] = 1'b1; e_sz[1] = 2'd2; e_a[1] = 32'h32;
    e_wr[2] = 1'b0; e_sz[2] = 2'd2; e_a[2] = 32'(DEPTH - 2);
    e_wr[3] = 1'b1; e_sz[3] = 2'd3; e_a[3] = 32'h30;
    for (int i = 0; i < 4; i++) begin
      run_op("errcase", e_wr[i], e_sz[i], 1'b0, e_a[i], 32'hFFFFFFFF, rd);
      chk("errcase_flag", 32'(rsp_error_last(e_wr[i])), 32'd1);
      run_op("err_lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd);
      chk("err_lw30_lit", rd, 32'h11223344);
    end

    // Backpressure.
    run_op("sw50", 1'b1, 2'd2, 1'b0, 32'h50, 32'h12345678, rd);
    rsp_ready = 1'b0;
    model_op(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, erd, eer, elat);
    send_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'(elat));
    chk("bp_rdata", rsp_rdata, erd);
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h50; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'h12345678);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {30'h0, rsp_valid, req_ready}, 32'h1);
    run_op("bp_lw50", 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, rd);
    chk("bp_lw50_lit", rd, 32'h12345678);

    // Reset while a load waits.
    run_op("swa5", 1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5A5A5, rd);
    send_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    chk("mr_no_rsp", 32'(seen), 32'd0);
    chk("mr_ready_back", 32'(req_ready), 32'd1);
    run_op("mr_lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd);
    chk("mr_lw40_lit", rd, 32'hA5A5A5A5);

    // Randomized traffic over an initialised window plus the top word.
    for (int i = 0; i < 64; i++) run_op("init", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd);
    run_op("init_top", 1'b1, 2'd2, 1'b0, 32'(DEPTH - 4), $urandom, rd);
    for (int i = 0; i < 200; i++) begin
      int          r;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] wd;
      r   = int'($urandom_range(0, 99));
      wr  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (r < 8) begin
        a = 32'h80000000 | $urandom;
      end else if (r < 20) begin
        a = 32'(DEPTH - 4) + 32'($urandom_range(0, 3));
      end else begin
        a = 32'($urandom_range(0, 255));
        if (r < 70) a = (sz == 2'd1) ? (a & 32'hFFFFFFFE) : (a & 32'hFFFFFFFC);
      end
      run_op("rnd", wr, sz, uns, a, wd, rd);
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

  // Latched error flag of the most recent response, captured while valid.
  logic last_err = 1'b0;
  always @(negedge clk) if (rsp_valid === 1'b1) last_err <= rsp_error;

  function automatic logic rsp_error_last(input logic unused_wr);
    logic r;
    r = last_err | (unused_wr & 1'b0);
    return r;
  endfunction

endmodule
